reaction_timer: RTL

Sequential core of the reaction-time game.
- Picks a pseudo-random wait target and counts milliseconds up to it.
- Raises the GO light, then measures the player's reaction in milliseconds as a 13-bit result.
- Flags false starts and timeouts.
- The 13-bit result feeds the existing display and score-comparison logic.

---
 rtl/reaction_pkg.sv | 28 ++
 rtl/ms_prescaler.sv | 34 +++
 rtl/reaction_timer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game core.
//   state_t   : round-sequencing states
//   MS_W      : width of the millisecond result
//   MS_MAX    : saturation value of the millisecond result
//   LFSR_TAPS : feedback taps for x^13+x^4+x^3+x+1
//   lfsr_step : one Fibonacci shift of the 13-bit LFSR
package reaction_pkg;

    localparam int              MS_W      = 13;
    localparam logic [MS_W-1:0] MS_MAX    = 13'd8191;
    // Bit n-1 set for each polynomial term x^n (n = 13, 4, 3, 1).
    localparam logic [MS_W-1:0] LFSR_TAPS = 13'b1_0000_0000_1101;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        GO,
        RESULT
    } state_t;

    // Shift toward the MSB, feedback enters at bit 0. Bit 12 is always a tap,
    // so the step is invertible and a nonzero state never reaches zero.
    function automatic logic [MS_W-1:0] lfsr_step(input logic [MS_W-1:0] v);
        return {v[MS_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Millisecond prescaler: counts 0..CLK_PER_MS-1 and pulses tick on the last
// count, i.e. the cycle whose closing edge wraps the counter.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous restart; after a clr edge the next tick is sampled
//           exactly CLK_PER_MS edges later
//   tick  : one-cycle millisecond pulse
module ms_prescaler #(
    parameter int CLK_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_PER_MS);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game core: random wait, GO light, reaction measurement in ms.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   start        : one-cycle pulse, begins a round from IDLE or RESULT
//   btn          : one-cycle player press
//   led_go       : GO light, high only in GO
//   busy         : high in ARM, WAIT and GO
//   done         : RESULT after a valid press
//   false_start  : RESULT after a press during WAIT
//   timeout      : RESULT after the count saturated
//   ms_count     : live count in WAIT/GO, frozen result in RESULT
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ARM    | one cycle: latch random target, clear count
// WAIT   | counting ms toward target; a press here is a false start
// GO     | light on, measuring reaction
// RESULT | flags and frozen count shown until next start
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int              CLK_PER_MS   = 50000,
    parameter int              MIN_DELAY_MS = 1000,
    parameter logic [MS_W-1:0] RAND_MASK    = 13'h0FFF,
    parameter logic [MS_W-1:0] LFSR_SEED    = 13'h1ACE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            btn,
    output logic            led_go,
    output logic            busy,
    output logic            done,
    output logic            false_start,
    output logic            timeout,
    output logic [MS_W-1:0] ms_count
);

    state_t          r_state;
    logic [MS_W-1:0] r_lfsr;
    logic [MS_W-1:0] r_target;

    logic            w_tick;
    logic            w_clr;
    logic            w_hit;
    logic [MS_W-1:0] w_ms_inc;
    logic [MS_W-1:0] w_target;

    assign w_ms_inc = ms_count + 1'b1;
    // The sum is deliberately truncated to 13 bits; a zero target then
    // means "go on the first tick".
    assign w_target = MS_W'(MIN_DELAY_MS) + (r_lfsr & RAND_MASK);
    assign w_hit    = w_tick && ((w_ms_inc == r_target) || (r_target == '0));
    // Restart the prescaler when entering WAIT (from ARM) and GO. The GO
    // entry already coincides with a wrap, clearing it keeps that explicit.
    assign w_clr    = (r_state == ARM) || ((r_state == WAIT) && !btn && w_hit);

    ms_prescaler #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lfsr      <= LFSR_SEED;
            r_target    <= '0;
            led_go      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            ms_count    <= '0;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= ARM;
                        busy     <= 1'b1;
                        ms_count <= '0;
                    end
                end
                ARM: begin
                    r_target <= w_target;
                    ms_count <= '0;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    // A press wins over a coinciding target tick.
                    if (btn) begin
                        r_state     <= RESULT;
                        false_start <= 1'b1;
                        busy        <= 1'b0;
                    end else if (w_hit) begin
                        r_state  <= GO;
                        ms_count <= '0;
                        led_go   <= 1'b1;
                    end else if (w_tick) begin
                        ms_count <= w_ms_inc;
                    end
                end
                GO: begin
                    // A press keeps the pre-increment value even on the
                    // saturating tick.
                    if (btn) begin
                        r_state <= RESULT;
                        done    <= 1'b1;
                        led_go  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (w_tick) begin
                        ms_count <= w_ms_inc;
                        if (w_ms_inc == MS_MAX) begin
                            r_state <= RESULT;
                            timeout <= 1'b1;
                            led_go  <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                end
                RESULT: begin
                    if (start) begin
                        r_state     <= ARM;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        false_start <= 1'b0;
                        timeout     <= 1'b0;
                        ms_count    <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
